// File: rtl/lcd_status_reader.sv
// ============================================================================
// Module   : lcd_status_reader
// Purpose  : 4-bit LCD status read (RS=0, RW=1) returning {busy_flag, addr}.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_status_reader #(
  parameter int SETUP_CYC  = 2,
  parameter int E_HIGH_CYC = 12,
  parameter int GAP_CYC    = 50,
  parameter int HOLD_CYC   = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done,
  input  logic       start,
  input  logic [3:0] SF_D_in,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       sf_d_oe,
  output logic       busy,
  output logic       valid,
  output logic [7:0] status
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_E1, S_GAP, S_E2, S_HOLD, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] C_SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] C_EHIGH_LAST = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_nib_hi;
  logic [3:0]       r_nib_lo;
  logic             w_phase_end;

  // Register select is fixed: this block only ever reads the status register.
  assign LCD_RS = 1'b0;

  always_comb begin
    w_phase_end = 1'b0;
    case (r_state)
      S_ADDR:  w_phase_end = (r_cnt == C_SETUP_LAST);
      S_E1:    w_phase_end = (r_cnt == C_EHIGH_LAST);
      S_GAP:   w_phase_end = (r_cnt == C_GAP_LAST);
      S_E2:    w_phase_end = (r_cnt == C_EHIGH_LAST);
      S_HOLD:  w_phase_end = (r_cnt == C_HOLD_LAST);
      S_DONE:  w_phase_end = 1'b1;
      default: w_phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_nib_hi <= 4'h0;
      r_nib_lo <= 4'h0;
      LCD_E    <= 1'b0;
      LCD_RW   <= 1'b0;
      sf_d_oe  <= 1'b1;
      busy     <= 1'b0;
      valid    <= 1'b0;
      status   <= 8'h00;
    end else begin
      if (r_state == S_IDLE || w_phase_end)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          if (start && init_done) begin
            r_state <= S_ADDR;
            LCD_RW  <= 1'b1;
            sf_d_oe <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_ADDR: if (w_phase_end) begin
          r_state <= S_E1;
          LCD_E   <= 1'b1;
        end
        S_E1: if (w_phase_end) begin
          r_state  <= S_GAP;
          LCD_E    <= 1'b0;
          r_nib_hi <= SF_D_in;
        end
        S_GAP: if (w_phase_end) begin
          r_state <= S_E2;
          LCD_E   <= 1'b1;
        end
        S_E2: if (w_phase_end) begin
          r_state  <= S_HOLD;
          LCD_E    <= 1'b0;
          r_nib_lo <= SF_D_in;
        end
        // Both nibbles are staged so status changes only together with valid.
        S_HOLD: if (w_phase_end) begin
          r_state <= S_DONE;
          LCD_RW  <= 1'b0;
          valid   <= 1'b1;
          status  <= {r_nib_hi, r_nib_lo};
        end
        S_DONE: begin
          r_state <= S_IDLE;
          valid   <= 1'b0;
          busy    <= 1'b0;
          sf_d_oe <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_status_reader.sv
// Directed bench for lcd_status_reader: cycle-exact timing model plus a
// status scoreboard popped on every valid pulse.
`default_nettype none

module tb_lcd_status_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_done;
  logic       start;
  logic [3:0] SF_D_in;
  logic       LCD_E, LCD_RS, LCD_RW, sf_d_oe, busy, valid;
  logic [7:0] status;

  int         passed = 0;
  int         total = 0;
  int         valid_cnt = 0;
  logic [7:0] exp_status = 8'h00;
  logic [7:0] sb[$];

  lcd_status_reader dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .start     (start),
    .SF_D_in   (SF_D_in),
    .LCD_E     (LCD_E),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .sf_d_oe   (sf_d_oe),
    .busy      (busy),
    .valid     (valid),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // {E, RS, RW, oe, busy, valid} k cycles after the accept edge.
  function automatic logic [5:0] exp_vec(input int k);
    logic e;
    e = (k >= 2 && k <= 13) || (k >= 64 && k <= 75);
    return {e, 1'b0, (k <= 77), (k == 79), (k <= 78), (k == 78)};
  endfunction

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      logic [8:0] want;
      valid_cnt++;
      want = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h100;
      check("sb_status", {23'd0, 1'b0, status}, {23'd0, want});
    end
  end

  task automatic do_read(input logic [3:0] hi, input logic [3:0] lo, input int x1, input int x2);
    logic [7:0] prev;
    prev      = exp_status;
    start     = 1'b1;
    init_done = 1'b1;
    SF_D_in   = 4'hF;
    sb.push_back({hi, lo});
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 80; k++) begin
      check($sformatf("cycle_k%0d", k),
            {18'd0, LCD_E, LCD_RS, LCD_RW, sf_d_oe, busy, valid, status},
            {18'd0, exp_vec(k), (k >= 78) ? {hi, lo} : prev});
      start   = (k + 1 == x1) || (k + 1 == x2);
      SF_D_in = (k == 13) ? hi : (k == 75) ? lo : 4'hF;
      if (k < 79) begin
        @(posedge clk); #1;
      end
    end
    start      = 1'b0;
    exp_status = {hi, lo};
  endtask

  initial begin
    reset     = 1'b0;
    init_done = 1'b0;
    start     = 1'b0;
    SF_D_in   = 4'hF;
    #12;
    check("reset_vals", {18'd0, LCD_E, LCD_RS, LCD_RW, sf_d_oe, busy, valid, status},
          {18'd0, 6'b000100, 8'h00});
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Starts without init_done are ignored.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 100) start = 1'b1;
      if (i == 101) start = 1'b0;
      check("no_init_idle", {18'd0, LCD_E, LCD_RS, LCD_RW, sf_d_oe, busy, valid, status},
            {18'd0, 6'b000100, 8'h00});
      @(posedge clk); #1;
    end

    do_read(4'h8, 4'h5, 10, 78);   // extra starts while busy
    do_read(4'h3, 4'hC, 79, -1);   // launched at t0+80; start during DONE
    do_read(4'hA, 4'h7, -1, -1);   // launched back-to-back at t0+80
    check("valid_count_3", valid_cnt, 3);

    // Reset in the middle of GAP aborts without a valid.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_async", {18'd0, LCD_E, LCD_RS, LCD_RW, sf_d_oe, busy, valid, status},
          {18'd0, 6'b000100, 8'h00});
    exp_status = 8'h00;
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    check("abort_no_valid", valid_cnt, 3);

    do_read(4'h0, 4'h0, -1, -1);   // bus floats at F except on the sample edges
    do_read(4'hE, 4'h1, -1, -1);
    check("valid_count_5", valid_cnt, 5);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lcd_status_reader.md
Name: lcd_status_reader

Overview:
- Read-side companion to the LCD init/write path on the 4-bit character LCD interface (50 MHz system clock).
- Once initialisation reports done, performs on request a complete 4-bit read transaction with RS=0, RW=1.
- Returns the 8-bit status byte: busy flag in bit 7, address counter in bits 6:0.
- Used by the command sequencer to poll busy instead of relying on fixed delays; owns LCD_E/LCD_RW/LCD_RS and the data-bus output enable while busy.

Parameters:
- SETUP_CYC, 2, cycles RS/RW held stable before first E rise (tAS ≥ 40 ns).
- E_HIGH_CYC, 12, cycles LCD_E is high per nibble (≥ 230 ns); data sampled on the last one.
- GAP_CYC, 50, cycles LCD_E is low between upper and lower nibble (≥ 1 µs).
- HOLD_CYC, 2, cycles RW held high after the second E fall.
- CNT_W, 8, width of the internal phase counter; must hold max(parameter)-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- init_done  input  1  high once LCD initialisation is complete; starts are ignored while low
- start  input  1  single-cycle read request
- SF_D_in  input  4  LCD data bus as seen by the FPGA (DB7..DB4)
- LCD_E  output  1  LCD enable strobe
- LCD_RS  output  1  register select (always 0 here: status read)
- LCD_RW  output  1  1 = read
- sf_d_oe  output  1  1 = FPGA may drive SF_D; 0 = bus released to the LCD
- busy  output  1  transaction in progress
- valid  output  1  one-cycle pulse; status holds new data
- status  output  8  {busy_flag, addr[6:0]}, held until the next valid

Behaviour:
- Async reset (reset=0):
  - State IDLE, counter 0.
  - LCD_E=0, LCD_RS=0, LCD_RW=0, sf_d_oe=1, busy=0, valid=0, status=8'h00.
- All outputs are registered.
- States and outputs:
  - IDLE: E=0, RW=0, oe=1.
  - ADDR: E=0, RW=1, oe=0, SETUP_CYC cycles.
  - E1: E=1, RW=1, oe=0, E_HIGH_CYC cycles.
  - GAP: E=0, RW=1, oe=0, GAP_CYC cycles.
  - E2: E=1, RW=1, oe=0, E_HIGH_CYC cycles.
  - HOLD: E=0, RW=1, oe=0, HOLD_CYC cycles.
  - DONE: E=0, RW=0, oe=0, valid=1, 1 cycle; then IDLE.
- Accept: start=1 and init_done=1 at a rising edge while in IDLE. From the next cycle busy=1 and the state is ADDR.
- Ignored starts: start while busy, or while init_done=0. No queuing, no error flag.
- Nibble capture:
  - On the edge that ends E1, SF_D_in → status[7:4].
  - On the edge that ends E2, SF_D_in → status[3:0].
  - Partial updates to status are not visible before valid.
- Bus turnaround: sf_d_oe falls together with RW rising. sf_d_oe returns to 1 only in IDLE, one cycle after RW has returned to 0 in DONE, so there is no contention.
- Timing with defaults (accept edge = t0):
  - LCD_E high after edges t0+2..t0+13 and t0+64..t0+75.
  - valid high after edge t0+78.
  - busy low and state IDLE after edge t0+79.
  - Total 79 cycles = SETUP+2·E_HIGH+GAP+HOLD+1.
- busy is 1 in every state except IDLE, including DONE.
- start arriving in the DONE cycle is ignored. A start in the first IDLE cycle is accepted.
- init_done falling mid-transaction has no effect; the transaction completes.
- reset asserted mid-transaction: immediate return to reset values; LCD_E drops asynchronously; status clears to 0; no valid pulse.
- The phase counter reloads to 0 on every state change and never wraps within a state.

Test Plan:
- Reset then init_done=0, pulse start → no change; busy=0, LCD_RW=0, sf_d_oe=1 for 200 cycles.
- init_done=1, start at t0, SF_D_in=4'h8 during E1 and 4'h5 during E2 → LCD_E high exactly 12 cycles twice with a 50-cycle gap; valid after edge t0+78; status=8'h85; busy low after t0+79.
- Bus turnaround check over the whole transaction → sf_d_oe=0 whenever LCD_RW=1; sf_d_oe=1 only when LCD_RW has been 0 for ≥1 cycle; LCD_RS=0 throughout.
- Extra start pulses at t0+10 and t0+78 → still exactly one valid pulse; a start at t0+80 launches a second read with status updated only at its valid.
- Assert reset at t0+40 (inside GAP) → LCD_E=0, LCD_RW=0, busy=0, status=8'h00 immediately; no valid; a new start after release completes normally.
- Change SF_D_in outside the final E-high cycles (e.g. 4'hF everywhere except the sample cycles) → status reflects only the values at the sample edges.
